// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions: polynomial, byte-parallel update and checker FSM encoding.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } crc_state_e;

  // MSB-first, non-reflected update: d[i] meets c[24+i]; init 0, no final XOR.
  function automatic logic [31:0] crc32_byte_f(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {d, 24'h00_0000};
    for (int i = 0; i < 8; i++) begin
      r = r[31] ? ((r << 1) ^ CRC32_POLY) : (r << 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_strip_dly.sv
// Four-byte delay line that holds back the trailing CRC bytes of a frame.
module crc32_strip_dly
  import crc32_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       flush,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last
);

  logic [3:0][7:0] sr_q, sr_d;
  logic [2:0]      fill_q, fill_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_last_q, out_last_d;

  always_comb begin
    sr_d        = sr_q;
    fill_d      = fill_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_last_d  = 1'b0;
    if (flush) begin
      fill_d = 3'd0;
    end else if (in_valid) begin
      sr_d = {sr_q[2:0], in_data};
      // Only a full line releases a byte; the four bytes still held at in_last are the CRC.
      if (fill_q == 3'd4) begin
        out_valid_d = 1'b1;
        out_data_d  = sr_q[3];
        out_last_d  = in_last;
      end
      if (in_last) begin
        fill_d = 3'd0;
      end else if (fill_q != 3'd4) begin
        fill_d = fill_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q      <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: rtl/crc32_rx_checker.sv
// Receive-side CRC-32 checker: verifies zero residue, strips the CRC and counts frames.
module crc32_rx_checker
  import crc32_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_abort,
  output logic             done,
  output logic             crc_ok,
  output logic             len_err,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  crc_state_e       state_q, state_d;
  logic [31:0]      crc_q, crc_d, crc_next;
  logic [15:0]      cnt_q, cnt_d;
  logic [16:0]      cnt_inc;
  logic             done_q, done_d;
  logic             crc_ok_q, crc_ok_d;
  logic             len_err_q, len_err_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] ok_q, ok_d, bad_q, bad_d;
  logic             dly_accept, dly_flush;

  // A frame's first byte always folds into a zero register, whatever is left over.
  assign crc_next = crc32_byte_f((state_q == ST_IDLE) ? 32'h0 : crc_q, in_data);
  assign cnt_inc  = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    crc_ok_d   = 1'b0;
    len_err_d  = 1'b0;
    abort_d    = 1'b0;
    dly_accept = 1'b0;
    dly_flush  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dly_accept = 1'b1;
          crc_d      = crc_next;
          cnt_d      = 16'd1;
          if (in_last) begin
            done_d    = 1'b1;
            len_err_d = 1'b1;
            crc_d     = 32'h0;
            cnt_d     = 16'd0;
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (in_valid) begin
          crc_d = crc_next;
          cnt_d = cnt_inc[15:0];
          if (in_last) begin
            dly_accept = 1'b1;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
            crc_d      = 32'h0;
            cnt_d      = 16'd0;
            if (cnt_inc < 17'd5) begin
              len_err_d = 1'b1;
            end else begin
              crc_ok_d = (crc_next == 32'h0);
            end
          end else if (cnt_inc == 17'(MAX_LEN)) begin
            // Too long: drop what the delay line holds and swallow the rest of the frame.
            abort_d   = 1'b1;
            dly_flush = 1'b1;
            state_d   = ST_DISCARD;
          end else begin
            dly_accept = 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        if (in_valid && in_last) begin
          done_d    = 1'b1;
          len_err_d = 1'b1;
          state_d   = ST_IDLE;
          crc_d     = 32'h0;
          cnt_d     = 16'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ok_d  = ok_q;
    bad_d = bad_q;
    if (done_d) begin
      if (crc_ok_d) begin
        if (ok_q != '1) ok_d = ok_q + CNT_W'(1);
      end else begin
        if (bad_q != '1) bad_d = bad_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      crc_q     <= 32'h0;
      cnt_q     <= 16'd0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      len_err_q <= 1'b0;
      abort_q   <= 1'b0;
      ok_q      <= '0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      crc_ok_q  <= crc_ok_d;
      len_err_q <= len_err_d;
      abort_q   <= abort_d;
      ok_q      <= ok_d;
      bad_q     <= bad_d;
    end
  end

  crc32_strip_dly u_dly (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (dly_accept),
    .in_data   (in_data),
    .in_last   (in_last),
    .flush     (dly_flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  assign out_abort = abort_q;
  assign done      = done_q;
  assign crc_ok    = crc_ok_q;
  assign len_err   = len_err_q;
  assign ok_cnt    = ok_q;
  assign bad_cnt   = bad_q;

endmodule

// File: tb/tb_crc32_rx_checker.sv
// Scoreboard bench for crc32_rx_checker with a short MAX_LEN and narrow counters.
module tb_crc32_rx_checker;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_last = 1'b0;
  logic             out_valid, out_last, out_abort, done, crc_ok, len_err;
  logic [7:0]       out_data;
  logic [CNT_W-1:0] ok_cnt, bad_cnt;

  int total = 0;
  int bad   = 0;

  logic [8:0] pay_q[$];
  logic [1:0] vrd_q[$];
  int         abort_exp = 0;
  int         ok_m = 0;
  int         bad_m = 0;
  logic [7:0] frm[$];

  crc32_rx_checker #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_abort (out_abort),
    .done      (done),
    .crc_ok    (crc_ok),
    .len_err   (len_err),
    .ok_cnt    (ok_cnt),
    .bad_cnt   (bad_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        if (pay_q.size() == 0) begin
          chk("out_extra", 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          e = pay_q.pop_front();
          chk("out_data", {24'h0, out_data}, {24'h0, e[7:0]});
          chk("out_last", {31'h0, out_last}, {31'h0, e[8]});
        end
      end
      if (out_abort) begin
        chk("abort_unexp", {31'h0, abort_exp > 0}, 32'd1);
        abort_exp--;
      end
      if (done) begin
        if (vrd_q.size() == 0) begin
          chk("done_extra", 32'd1, 32'd0);
        end else begin
          logic [1:0] v;
          v = vrd_q.pop_front();
          chk("crc_ok", {31'h0, crc_ok}, {31'h0, v[1]});
          chk("len_err", {31'h0, len_err}, {31'h0, v[0]});
          if (v[1]) begin
            if (ok_m != 3) ok_m++;
          end else begin
            if (bad_m != 3) bad_m++;
          end
          chk("ok_cnt", {30'h0, ok_cnt}, ok_m);
          chk("bad_cnt", {30'h0, bad_cnt}, bad_m);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pushes the expected payload and verdict for frm, then drives it.
  task automatic send_frame(input int gap_idx, input logic exp_ok);
    int len;
    len = frm.size();
    if (len < 5) begin
      vrd_q.push_back(2'b01);
    end else if (len <= MAX_LEN) begin
      for (int i = 0; i < len - 4; i++) pay_q.push_back({(i == len - 5), frm[i]});
      vrd_q.push_back({exp_ok, 1'b0});
    end else begin
      for (int i = 0; i < MAX_LEN - 5; i++) pay_q.push_back({1'b0, frm[i]});
      abort_exp++;
      vrd_q.push_back(2'b01);
    end
    for (int i = 0; i < len; i++) begin
      drive(frm[i], i == len - 1);
      if (i == gap_idx) idle(2);
    end
  endtask

  task automatic chk_outputs_zero();
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_data", {24'h0, out_data}, 32'd0);
    chk("rst_out_last", {31'h0, out_last}, 32'd0);
    chk("rst_out_abort", {31'h0, out_abort}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_crc_ok", {31'h0, crc_ok}, 32'd0);
    chk("rst_len_err", {31'h0, len_err}, 32'd0);
    chk("rst_ok_cnt", {30'h0, ok_cnt}, 32'd0);
    chk("rst_bad_cnt", {30'h0, bad_cnt}, 32'd0);
  endtask

  task automatic good_frame();
    frm = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB7};
    send_frame(-1, 1'b1);
  endtask

  initial begin
    #1;
    chk_outputs_zero();
    idle(2);
    rst = 1'b1;
    idle(1);

    good_frame();
    idle(3);
    frm = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB6};
    send_frame(-1, 1'b0);
    idle(3);
    frm = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(-1, 1'b0);
    idle(3);
    frm = {};
    for (int i = 0; i < 20; i++) frm.push_back(8'(8'h30 + i));
    send_frame(-1, 1'b0);
    idle(3);
    frm = '{8'hAA};
    send_frame(-1, 1'b0);
    idle(3);
    frm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(1, 1'b1);
    good_frame();
    idle(8);

    drive(8'h11, 1'b0);
    drive(8'h22, 1'b0);
    drive(8'h33, 1'b0);
    rst = 1'b0;
    ok_m = 0;
    bad_m = 0;
    #2;
    chk_outputs_zero();
    @(posedge clk);
    #3;
    rst = 1'b1;
    idle(1);

    good_frame();
    idle(2);
    frm = {};
    for (int i = 0; i < MAX_LEN; i++) frm.push_back(8'h00);
    send_frame(-1, 1'b1);
    good_frame();
    good_frame();
    idle(10);

    chk("pay_left", pay_q.size(), 32'd0);
    chk("vrd_left", vrd_q.size(), 32'd0);
    chk("abort_left", abort_exp, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
